// File: rtl/quadrature_step_generator.sv
// Quadrature/step-direction transmitter: walks position toward a latched target,
// one step per programmed period, emitting Gray-coded A/B plus step/dir strobes.
module quadrature_step_generator #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     target,
    input  logic [DIV_WIDTH-1:0] step_period,
    input  logic                 load_en,
    input  logic [WIDTH-1:0]     load_val,
    input  logic                 abort,
    output logic                 quad_a,
    output logic                 quad_b,
    output logic                 step_pulse,
    output logic                 step_dir,
    output logic [WIDTH-1:0]     position,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     pos_q, pos_d;
    logic [WIDTH-1:0]     target_q, target_d;
    logic [DIV_WIDTH-1:0] period_q, period_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           phase_q, phase_d;
    logic [1:0]           quad_q, quad_d;
    logic                 dir_q, dir_d;
    logic                 step_pulse_q, step_pulse_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     pos_next_step;

    // Phase index to (A,B): walking the index up makes A lead B.
    function automatic logic [1:0] phase_to_quad(input logic [1:0] p);
        case (p)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    always_comb begin
        // NOTE: every _d gets its default first, so no path through the case leaves a latch.
        state_d       = state_q;
        pos_d         = pos_q;
        target_d      = target_q;
        period_d      = period_q;
        cnt_d         = cnt_q;
        phase_d       = phase_q;
        dir_d         = dir_q;
        step_pulse_d  = 1'b0;
        done_d        = 1'b0;
        pos_next_step = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;

        case (state_q)
            IDLE: begin
                if (load_en) begin
                    pos_d = load_val;
                end else if (start) begin
                    if (target == pos_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = target;
                        period_d = (step_period == '0) ? DIV_WIDTH'(1) : step_period;
                        cnt_d    = period_d - 1'b1;
                        dir_d    = (target > pos_q);
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    pos_d        = pos_next_step;
                    phase_d      = dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
                    step_pulse_d = 1'b1;
                    cnt_d        = period_q - 1'b1;
                    // done lands on the same edge as the final step
                    if (pos_next_step == target_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        quad_d = phase_to_quad(phase_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pos_q        <= '0;
            target_q     <= '0;
            period_q     <= '0;
            cnt_q        <= '0;
            phase_q      <= 2'd0;
            quad_q       <= 2'b00;
            dir_q        <= 1'b0;
            step_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            target_q     <= target_d;
            period_q     <= period_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            quad_q       <= quad_d;
            dir_q        <= dir_d;
            step_pulse_q <= step_pulse_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign quad_a     = quad_q[1];
    assign quad_b     = quad_q[0];
    assign step_pulse = step_pulse_q;
    assign step_dir   = dir_q;
    assign position   = pos_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_quadrature_step_generator.sv
// Bench for quadrature_step_generator: table of directed moves, hand-written corner
// sequences and random moves, all checked cycle by cycle against an arithmetic model.
module tb_quadrature_step_generator;

    localparam int WIDTH     = 8;
    localparam int DIV_WIDTH = 16;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [WIDTH-1:0]     target;
    logic [DIV_WIDTH-1:0] step_period;
    logic                 load_en;
    logic [WIDTH-1:0]     load_val;
    logic                 abort;
    logic                 quad_a;
    logic                 quad_b;
    logic                 step_pulse;
    logic                 step_dir;
    logic [WIDTH-1:0]     position;
    logic                 busy;
    logic                 done;

    quadrature_step_generator #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .target(target),
        .step_period(step_period), .load_en(load_en), .load_val(load_val),
        .abort(abort), .quad_a(quad_a), .quad_b(quad_b), .step_pulse(step_pulse),
        .step_dir(step_dir), .position(position), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             a;
        logic             b;
        logic             sp;
        logic             dir;
        logic [WIDTH-1:0] pos;
        logic             busy;
        logic             done;
    } obs_t;

    typedef struct {
        int    s;
        int    t;
        int    per;
        int    abort_c;
        bit    noise;
        string name;
    } move_t;

    logic [1:0] quad_lut [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    int   checks   = 0;
    int   failures = 0;
    int   m_pos    = 0;
    int   m_phase  = 0;
    logic m_dir    = 1'b0;

    function automatic int mod4(input int x);
        return ((x % 4) + 4) % 4;
    endfunction

    function automatic obs_t make_obs(input int pos, input int phase, input logic dir,
                                      input logic sp, input logic bsy, input logic dn);
        obs_t o;
        logic [1:0] q;
        q      = quad_lut[mod4(phase)];
        o.a    = q[1];
        o.b    = q[0];
        o.sp   = sp;
        o.dir  = dir;
        o.pos  = WIDTH'(pos);
        o.busy = bsy;
        o.done = dn;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.a    = quad_a;
        o.b    = quad_b;
        o.sp   = step_pulse;
        o.dir  = step_dir;
        o.pos  = position;
        o.busy = busy;
        o.done = done;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got ab=%b%b sp=%b dir=%b pos=%0d busy=%b done=%b, expected ab=%b%b sp=%b dir=%b pos=%0d busy=%b done=%b",
                     name, got.a, got.b, got.sp, got.dir, got.pos, got.busy, got.done,
                     exp.a, exp.b, exp.sp, exp.dir, exp.pos, exp.busy, exp.done);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load s, start a move to t, and check every cycle until one past its end.
    task automatic run_move(input int s, input int t, input int per, input int abort_c,
                            input bit noise, input string name);
        int   p, n, k, eff, end_c, sign;
        logic dir, sp;
        load_en  = 1'b1;
        load_val = WIDTH'(s);
        tick();
        load_en = 1'b0;
        m_pos   = s;
        check({name, "/load"}, sample(), make_obs(m_pos, m_phase, m_dir, 1'b0, 1'b0, 1'b0));

        p = (per == 0) ? 1 : per;
        n = (t > s) ? t - s : s - t;
        dir = (t > s);
        start       = 1'b1;
        target      = WIDTH'(t);
        step_period = DIV_WIDTH'(per);
        tick();
        start = 1'b0;

        if (n == 0) begin
            check({name, "/zero_done"}, sample(), make_obs(m_pos, m_phase, m_dir, 1'b0, 1'b0, 1'b1));
            tick();
            check({name, "/zero_after"}, sample(), make_obs(m_pos, m_phase, m_dir, 1'b0, 1'b0, 1'b0));
            return;
        end

        m_dir = dir;
        sign  = dir ? 1 : -1;
        check({name, "/e0"}, sample(), make_obs(s, m_phase, m_dir, 1'b0, 1'b1, 1'b0));

        end_c = (abort_c != 0) ? abort_c : n * p;
        eff   = (abort_c != 0) ? abort_c - 1 : n * p;
        for (int c = 1; c <= end_c + 1; c++) begin
            if (abort_c != 0 && c == abort_c) abort = 1'b1;
            if (noise && c <= end_c) begin
                load_en     = 1'($urandom_range(0, 1));
                load_val    = WIDTH'($urandom);
                start       = 1'($urandom_range(0, 1));
                target      = WIDTH'($urandom);
                step_period = DIV_WIDTH'($urandom);
            end
            tick();
            abort   = 1'b0;
            load_en = 1'b0;
            start   = 1'b0;
            k  = ((c < eff) ? c : eff) / p;
            if (k > n) k = n;
            sp = (c % p == 0) && (c <= n * p) && !(abort_c != 0 && c >= abort_c);
            check($sformatf("%s/c%0d", name, c), sample(),
                  make_obs(s + sign * k, m_phase + sign * k, m_dir, sp,
                           c < end_c, (abort_c == 0) && (c == n * p)));
        end

        k       = (abort_c != 0) ? (abort_c - 1) / p : n;
        m_pos   = s + sign * k;
        m_phase = mod4(m_phase + sign * k);
    endtask

    move_t moves [5];

    initial begin
        int s, t, d, per, p, n, ac;

        moves[0] = '{s: 5,   t: 8,  per: 3, abort_c: 0, noise: 1'b0, name: "up_5_8_p3"};
        moves[1] = '{s: 8,   t: 6,  per: 0, abort_c: 0, noise: 1'b0, name: "down_8_6_p0"};
        moves[2] = '{s: 6,   t: 6,  per: 2, abort_c: 0, noise: 1'b0, name: "zero_dist"};
        moves[3] = '{s: 10,  t: 20, per: 4, abort_c: 8, noise: 1'b0, name: "abort_2nd"};
        moves[4] = '{s: 100, t: 90, per: 2, abort_c: 0, noise: 1'b1, name: "ignore_run"};

        rst = 1'b1; start = 1'b0; target = '0; step_period = '0;
        load_en = 1'b0; load_val = '0; abort = 1'b0;
        tick();
        tick();
        check("reset_held", sample(), make_obs(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;
        tick();
        check("reset_release", sample(), make_obs(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

        foreach (moves[i])
            run_move(moves[i].s, moves[i].t, moves[i].per, moves[i].abort_c,
                     moves[i].noise, moves[i].name);

        // Load and start together: load wins, no move begins.
        load_en = 1'b1; load_val = 8'd33; start = 1'b1; target = 8'd40; step_period = 16'd1;
        tick();
        load_en = 1'b0; start = 1'b0;
        m_pos = 33;
        check("load_vs_start", sample(), make_obs(33, m_phase, m_dir, 1'b0, 1'b0, 1'b0));
        tick();
        check("load_vs_start_next", sample(), make_obs(33, m_phase, m_dir, 1'b0, 1'b0, 1'b0));

        // Async reset between edges during a move.
        load_en = 1'b1; load_val = 8'd50;
        tick();
        load_en = 1'b0; start = 1'b1; target = 8'd60; step_period = 16'd2;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1 check("async_reset_immediate", sample(), make_obs(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        rst = 1'b0;
        tick();
        check("async_reset_after", sample(), make_obs(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        m_pos = 0; m_phase = 0; m_dir = 1'b0;

        for (int i = 0; i < 24; i++) begin
            s = $urandom_range(0, 255);
            d = $urandom_range(0, 24) - 12;
            t = s + d;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            per = $urandom_range(0, 4);
            p   = (per == 0) ? 1 : per;
            n   = (t > s) ? t - s : s - t;
            ac  = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n * p) : 0;
            run_move(s, t, per, ac, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quadrature_step_generator.md
Name: quadrature_step_generator

Overview:
- Transmit side of the quadrature/step-direction interface that our up/down position counters consume.
- Given a target position and a step period, the block walks its internal position toward the target one step at a time.
- For each step it emits a quadrature phase pair (A/B) plus step/dir strobes.
- Sits in the counters library as the stimulus/actuator end that drives downstream decoders and counters.

Parameters:
- WIDTH, 8, width of position, target and load value.
- DIV_WIDTH, 16, width of the step-period field (cycles per step).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- start  input  1  request a move to target (sampled in IDLE only).
- target  input  WIDTH  destination position, latched on accepted start.
- step_period  input  DIV_WIDTH  clk cycles per step, latched on accepted start; 0 treated as 1.
- load_en  input  1  overwrite position with load_val (IDLE only).
- load_val  input  WIDTH  value for load.
- abort  input  1  terminate a move in progress.
- quad_a  output  1  quadrature phase A.
- quad_b  output  1  quadrature phase B.
- step_pulse  output  1  one-cycle strobe, high in the cycle after each step edge.
- step_dir  output  1  1 = up, 0 = down; valid whenever busy.
- position  output  WIDTH  current position.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle strobe when target is reached.

Behaviour:
- Reset (async, immediate, including mid-move) values:
  - position = 0, phase index = 0 (quad_a = 0, quad_b = 0).
  - step_pulse, step_dir, busy, done = 0.
  - State = IDLE; interval counter = 0.
- Phase index p (2 bits) maps to (A,B): 0→00, 1→10, 2→11, 3→01.
  - Up step: p+1 mod 4 (A leads B).
  - Down step: p-1 mod 4.
- All outputs are registered.
- States:
  - IDLE:
    - load_en=1: position <= load_val; phase unchanged; start ignored that cycle (load has priority).
    - Else start=1 with target==position: stay IDLE; done=1 for the next cycle; no step.
    - Else start=1: latch target and period P (P = max(step_period, 1)).
      - step_dir <= (target > position), unsigned compare; no wrap-around traversal.
      - Interval counter <= P-1; busy <= 1; go RUN.
  - RUN, every edge:
    - abort=1: go IDLE, busy <= 0, no step, no done. Abort suppresses a step due that same edge.
    - Else counter != 0: decrement.
    - Else (step): position ±1 per step_dir, phase updated, step_pulse <= 1, counter <= P-1.
      - If the new position equals target: go IDLE, busy <= 0, done <= 1 on the same edge as the final step.
    - In RUN, load_en and start are ignored; inputs target and step_period are not re-sampled.
- Latency: with start accepted at edge E0, steps occur at edges E0+P, E0+2P, ….
  - Step count = |target - position|; done coincides with the last step_pulse.
- step_pulse and done are single-cycle; never held.
- Position arithmetic is WIDTH-bit.
  - Wrap is impossible because the direction always moves toward target within range.
- quad_a/quad_b change only on step edges, exactly one bit per step (Gray).

Test Plan:
- Reset/async:
  - Stimulus: assert rst between clock edges during a RUN move.
  - Required: all outputs read 0 immediately, before the next clk edge.
  - Required after release: IDLE, quad = 00.
- Up move:
  - Stimulus: load 5; start target=8, period=3.
  - Required: step_pulse at E0+3, +6, +9.
  - Required: position 6, 7, 8; (A,B) 00→10→11→01; step_dir = 1.
  - Required: done and busy falling coincide with the third step.
- Down move:
  - Stimulus: position 8, start target=6, period=0.
  - Required: period behaves as 1, so steps land on E0+1 and E0+2.
  - Required: (A,B) 01→11→10, step_dir = 0, done at E0+2.
- Zero-distance:
  - Stimulus: start with target == position.
  - Required: done high for exactly one cycle; busy stays 0; no step_pulse; quad unchanged.
- Abort:
  - Stimulus: start target=20 from 10 with period=4; abort asserted on the same cycle as the 2nd step's edge.
  - Required: only one step occurs; position = 11; no done; busy = 0.
- Ignore rules:
  - Stimulus: load_en and start together in IDLE.
  - Required: only the load takes effect.
  - Stimulus: load_en/start pulses during RUN.
  - Required: position and trajectory are unaffected.
